fetch_queue_unit: RTL and testbench

- Front-end fetch engine that drives the read side of the word-addressed instruction ROM.
- Owns the program counter and presents a 64-bit byte address each cycle.
- Captures the combinationally returned 32-bit instruction into a small FIFO and hands {pc, instruction} pairs to decode over a valid/ready handshake.
- Handles backpressure, branch redirects (with queue flush) and end-of-memory halting.

---
 rtl/fetch_queue_unit.sv | 104 ++++++++++
 tb/tb_fetch_queue_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: program-counter owner and instruction fetch queue.
// Reads one word per cycle from a combinational instruction ROM, buffers
// {pc, instruction} pairs in a small FIFO and hands them to decode over a
// valid/ready handshake. Supports redirect with flush and out-of-range halt.
module fetch_queue_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [63:0]               imem_addr,
    input  logic [31:0]               imem_instr,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [63:0]               out_pc,
    output logic                      fetch_halt,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [63:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    entry_t        r_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_halt;
    logic          w_not_full;
    logic [63:0]   w_redirect_pc;
    entry_t        w_head;

    // Fetch/queue control decisions for this cycle.
    always_comb begin
        w_halt        = (r_pc + 64'd3) >= 64'(MEM_SIZE);
        w_not_full    = r_count < CW'(DEPTH);
        w_pop         = (r_count != '0) & out_ready;
        w_push        = ~redirect_valid & ~w_halt & (w_not_full | w_pop);
        w_redirect_pc = redirect_pc & ~64'd3;
        w_head        = r_mem[r_head];
    end

    // PC, pointers and occupancy; redirect flushes and overrides push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 64'd4;
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are only observed through the count-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: r_pc, instr: imem_instr};
        end
    end

    // Output drive: head entry when occupied, zeros when empty.
    always_comb begin
        imem_addr  = r_pc;
        fetch_halt = w_halt;
        count      = r_count;
        out_valid  = r_count != '0;
        out_instr  = '0;
        out_pc     = '0;
        if (out_valid) begin
            out_instr = w_head.instr;
            out_pc    = w_head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed testbench for fetch_queue_unit with a ROM model where mem[i] = i.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_halt;
    logic [2:0]  count;

    int n_cmp;
    int n_bad;

    fetch_queue_unit #(.DEPTH(4), .MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_halt     (fetch_halt),
        .count          (count)
    );

    // ROM: word i holds value i.
    assign imem_instr = imem_addr[33:2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, 64'(out_instr), 64'(ins));
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        out_ready      = 1'b1;
        #3;

        // Reset state
        chk("rst_addr",  imem_addr, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_halt",  64'(fetch_halt), 64'd0);
        chk("rst_pc",    out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);

        // Streaming with out_ready=1
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("st1_addr", imem_addr, 64'd4);
        chk_head("st1", 64'd0, 32'd0);
        chk("st1_count", 64'(count), 64'd1);
        tick();
        chk("st2_addr", imem_addr, 64'd8);
        chk_head("st2", 64'd4, 32'd1);
        tick();
        chk_head("st3", 64'd8, 32'd2);
        chk("st3_count", 64'(count), 64'd1);

        // Backpressure fill to DEPTH
        out_ready = 1'b0;
        do_reset();
        chk("bp1_count", 64'(count), 64'd1);
        tick(); tick(); tick();
        chk("bp4_count", 64'(count), 64'd4);
        chk("bp4_addr",  imem_addr, 64'd16);
        tick();
        chk("bp5_count", 64'(count), 64'd4);
        chk("bp5_addr",  imem_addr, 64'd16);
        chk_head("bp5", 64'd0, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bpp_count", 64'(count), 64'd4);
        chk("bpp_addr",  imem_addr, 64'd20);
        chk_head("bpp", 64'd4, 32'd1);

        // Redirect with 3 entries queued
        do_reset();
        tick(); tick();
        chk("rd_pre_count", 64'(count), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h43;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("rd_count", 64'(count), 64'd0);
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_addr",  imem_addr, 64'h40);
        chk("rd_pc0",   out_pc, 64'd0);
        tick();
        chk_head("rd_head", 64'h40, 32'd16);

        // Redirect near end of memory, then halt
        redirect_valid = 1'b1;
        redirect_pc    = 64'd1016;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("eom_addr", imem_addr, 64'd1016);
        chk("eom_halt0", 64'(fetch_halt), 64'd0);
        tick(); tick();
        chk("eom_halt", 64'(fetch_halt), 64'd1);
        chk("eom_addr2", imem_addr, 64'd1024);
        chk("eom_count", 64'(count), 64'd2);
        tick();
        chk("eom_nopush", 64'(count), 64'd2);
        chk("eom_addr3", imem_addr, 64'd1024);
        chk_head("eom_h0", 64'd1016, 32'd254);
        out_ready = 1'b1;
        tick();
        chk_head("eom_h1", 64'd1020, 32'd255);
        tick();
        chk("eom_drain", 64'(count), 64'd0);
        chk("eom_dvalid", 64'(out_valid), 64'd0);
        tick();
        chk("eom_still", 64'(fetch_halt), 64'd1);

        // Redirect out of bounds halts immediately
        redirect_valid = 1'b1;
        redirect_pc    = 64'd2000;
        tick();
        chk("oob_halt",  64'(fetch_halt), 64'd1);
        chk("oob_count", 64'(count), 64'd0);
        chk("oob_addr",  imem_addr, 64'd2000);

        // Redirect to 0 resumes fetch
        redirect_pc = 64'd0;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("res_halt", 64'(fetch_halt), 64'd0);
        chk("res_addr", imem_addr, 64'd0);
        tick();
        chk_head("res_h", 64'd0, 32'd0);
        tick();
        chk("res_count", 64'(count), 64'd2);

        // Asynchronous reset mid-stream
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_addr",  imem_addr, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Redirect and pop together with one entry queued
        chk("rp_count", 64'(count), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("rp_flush", 64'(count), 64'd0);
        chk("rp_addr",  imem_addr, 64'h100);
        tick();
        chk_head("rp_h0", 64'h100, 32'd64);
        chk("rp_count1", 64'(count), 64'd1);
        tick();
        chk_head("rp_h1", 64'h104, 32'd65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
